// File: rtl/etx_packet_arbiter.sv
// Three-source emesh packet arbiter (read-response, write, read-request) feeding a registered elink TX port.
// Define ETX_ARB_RR_EN for rotating priority; otherwise fixed priority rr > wr > rd.
module etx_packet_arbiter #(
  parameter int PW = 104
) (
  input  logic          sys_clk,
  input  logic          sys_nreset,
  input  logic          rr_access_in,
  input  logic [PW-1:0] rr_packet_in,
  output logic          rr_wait_out,
  input  logic          wr_access_in,
  input  logic [PW-1:0] wr_packet_in,
  output logic          wr_wait_out,
  input  logic          rd_access_in,
  input  logic [PW-1:0] rd_packet_in,
  output logic          rd_wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  output logic [2:0]    grant_out
);

  logic          ld;
  logic [2:0]    req;
  logic [2:0]    win;
  logic [2:0]    gnt;
  logic [PW-1:0] pkt_sel;

  assign req = {rd_access_in, wr_access_in, rr_access_in};
  assign ld  = ~(access_out & wait_in);
  assign gnt = win & {3{ld}};

`ifdef ETX_ARB_RR_EN
  logic [1:0] ptr;
  logic [2:0] rot;
  logic [2:0] rot_win;

  // Rotate requests so the pointer's source sits at bit 0, pick lowest, rotate back.
  always_comb begin
    rot     = req;
    rot_win = '0;
    win     = '0;
    case (ptr)
      2'd1:    rot = {req[0], req[2:1]};
      2'd2:    rot = {req[1:0], req[2]};
      default: rot = req;
    endcase
    if (rot[0])      rot_win = 3'b001;
    else if (rot[1]) rot_win = 3'b010;
    else if (rot[2]) rot_win = 3'b100;
    case (ptr)
      2'd1:    win = {rot_win[1:0], rot_win[2]};
      2'd2:    win = {rot_win[0], rot_win[2:1]};
      default: win = rot_win;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      ptr <= 2'd0;
    end else if (|gnt) begin
      if (gnt[0])      ptr <= 2'd1;
      else if (gnt[1]) ptr <= 2'd2;
      else             ptr <= 2'd0;
    end
  end
`else
  always_comb begin
    win = '0;
    if (req[0])      win = 3'b001;
    else if (req[1]) win = 3'b010;
    else if (req[2]) win = 3'b100;
  end
`endif

  always_comb begin
    pkt_sel = '0;
    if (win[0])      pkt_sel = rr_packet_in;
    else if (win[1]) pkt_sel = wr_packet_in;
    else if (win[2]) pkt_sel = rd_packet_in;
  end

  // Reset forces every source to wait, independent of the output register state.
  assign rr_wait_out = ~sys_nreset | (req[0] & ~gnt[0]);
  assign wr_wait_out = ~sys_nreset | (req[1] & ~gnt[1]);
  assign rd_wait_out = ~sys_nreset | (req[2] & ~gnt[2]);

  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      access_out <= 1'b0;
      packet_out <= '0;
      grant_out  <= '0;
    end else if (ld) begin
      access_out <= |req;
      grant_out  <= gnt;
      if (|req) packet_out <= pkt_sel;
    end
  end

endmodule

// File: tb/tb_etx_packet_arbiter.sv
// Scoreboard bench for etx_packet_arbiter: directed vectors push expected grants; a monitor pops and compares.
// Expected winners are hand-listed for both the ETX_ARB_RR_EN and fixed-priority builds.
module tb_etx_packet_arbiter;

  localparam int PW = 104;
`ifdef ETX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sys_nreset;
  logic          rr_access_in, wr_access_in, rd_access_in;
  logic [PW-1:0] rr_packet_in, wr_packet_in, rd_packet_in;
  logic          rr_wait_out, wr_wait_out, rd_wait_out;
  logic          access_out;
  logic [PW-1:0] packet_out;
  logic          wait_in;
  logic [2:0]    grant_out;

  int total = 0;
  int bad   = 0;
  logic [PW+2:0] sb[$];
  int unsigned   cnt[3];
  logic [2:0]    last_win = '0;

  etx_packet_arbiter #(.PW(PW)) dut (
    .sys_clk      (clk),
    .sys_nreset   (sys_nreset),
    .rr_access_in (rr_access_in),
    .rr_packet_in (rr_packet_in),
    .rr_wait_out  (rr_wait_out),
    .wr_access_in (wr_access_in),
    .wr_packet_in (wr_packet_in),
    .wr_wait_out  (wr_wait_out),
    .rd_access_in (rd_access_in),
    .rd_packet_in (rd_packet_in),
    .rd_wait_out  (rd_wait_out),
    .access_out   (access_out),
    .packet_out   (packet_out),
    .wait_in      (wait_in),
    .grant_out    (grant_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int i, input int unsigned c);
    logic [7:0] tag;
    case (i)
      0:       tag = 8'h5A;
      1:       tag = 8'h6B;
      default: tag = 8'h7C;
    endcase
    return {tag, 96'(c)};
  endfunction

  function automatic logic [PW-1:0] src_pkt(input logic [2:0] w);
    if (w[0]) return rr_packet_in;
    if (w[1]) return wr_packet_in;
    return rd_packet_in;
  endfunction

  // One cycle of stimulus; w_rr / w_fx are the hand-computed winners for each build.
  task automatic step(input logic [2:0] req, input logic [2:0] w_rr, input logic [2:0] w_fx, input logic wt);
    logic [2:0] w;
    w = RR ? w_rr : w_fx;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (last_win[i]) cnt[i]++;
    rr_access_in = req[0];
    wr_access_in = req[1];
    rd_access_in = req[2];
    rr_packet_in = mk(0, cnt[0]);
    wr_packet_in = mk(1, cnt[1]);
    rd_packet_in = mk(2, cnt[2]);
    wait_in      = wt;
    #3;
    chk("wait_out", 128'({rd_wait_out, wr_wait_out, rr_wait_out}), 128'(req & ~w));
    if (w != 3'b000) sb.push_back({w, src_pkt(w)});
    last_win = w;
  endtask

  // Monitor: every new presentation on the output pops one expected entry.
  initial begin
    logic          prev_acc;
    logic          prev_wait;
    logic [PW-1:0] prev_pkt;
    logic [2:0]    prev_gnt;
    logic [PW+2:0] exp;
    prev_acc  = 1'b0;
    prev_wait = 1'b0;
    prev_pkt  = '0;
    prev_gnt  = '0;
    forever begin
      @(negedge clk);
      if (!sys_nreset) begin
        prev_acc = 1'b0;
      end else begin
        if (access_out) begin
          if (prev_acc && prev_wait) begin
            chk("held_packet", 128'(packet_out), 128'(prev_pkt));
            chk("held_grant", 128'(grant_out), 128'(prev_gnt));
          end else if (sb.size() == 0) begin
            chk("unexpected_output", 128'({grant_out, packet_out}), 128'(0));
          end else begin
            exp = sb.pop_front();
            chk("grant_packet", 128'({grant_out, packet_out}), 128'(exp));
          end
        end else begin
          chk("idle_grant", 128'(grant_out), 128'(0));
        end
        prev_acc  = access_out;
        prev_wait = wait_in;
        prev_pkt  = packet_out;
        prev_gnt  = grant_out;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    sys_nreset   = 1'b0;
    wait_in      = 1'b0;
    rr_access_in = 1'b1;
    wr_access_in = 1'b1;
    rd_access_in = 1'b1;
    rr_packet_in = mk(0, 99);
    wr_packet_in = mk(1, 99);
    rd_packet_in = mk(2, 99);
    #3;
    chk("rst_access", 128'(access_out), 128'(0));
    chk("rst_grant", 128'(grant_out), 128'(0));
    chk("rst_packet", 128'(packet_out), 128'(0));
    chk("rst_waits", 128'({rd_wait_out, wr_wait_out, rr_wait_out}), 128'(3'b111));
    @(posedge clk);
    #1;
    chk("rst_access_edge", 128'(access_out), 128'(0));
    rr_access_in = 1'b0;
    wr_access_in = 1'b0;
    rd_access_in = 1'b0;
    #1 sys_nreset = 1'b1;

    // First packet from rr.
    step(3'b001, 3'b001, 3'b001, 1'b0);
    step(3'b000, 3'b000, 3'b000, 1'b0);
    // All sources continuous, no backpressure.
    step(3'b111, 3'b010, 3'b001, 1'b0);
    step(3'b111, 3'b100, 3'b001, 1'b0);
    step(3'b111, 3'b001, 3'b001, 1'b0);
    step(3'b111, 3'b010, 3'b001, 1'b0);
    step(3'b111, 3'b100, 3'b001, 1'b0);
    step(3'b111, 3'b001, 3'b001, 1'b0);
    // Backpressure for 5 cycles: nothing granted, output held.
    for (int k = 0; k < 5; k++) step(3'b111, 3'b000, 3'b000, 1'b1);
    step(3'b111, 3'b010, 3'b001, 1'b0);
    step(3'b111, 3'b100, 3'b001, 1'b0);
    step(3'b000, 3'b000, 3'b000, 1'b0);
    // Priority among subsets.
    step(3'b100, 3'b100, 3'b100, 1'b0);
    step(3'b110, 3'b010, 3'b010, 1'b0);
    step(3'b110, 3'b100, 3'b010, 1'b0);
    step(3'b000, 3'b000, 3'b000, 1'b0);
    // Reset mid-transfer while stalled.
    step(3'b001, 3'b001, 3'b001, 1'b0);
    step(3'b000, 3'b000, 3'b000, 1'b1);
    #2;
    rr_access_in = 1'b1;
    wr_access_in = 1'b1;
    rd_access_in = 1'b1;
    #1 sys_nreset = 1'b0;
    #1;
    chk("midrst_access", 128'(access_out), 128'(0));
    chk("midrst_grant", 128'(grant_out), 128'(0));
    chk("midrst_packet", 128'(packet_out), 128'(0));
    chk("midrst_waits", 128'({rd_wait_out, wr_wait_out, rr_wait_out}), 128'(3'b111));
    @(posedge clk);
    #1;
    chk("midrst_access_edge", 128'(access_out), 128'(0));
    rr_access_in = 1'b0;
    wr_access_in = 1'b0;
    rd_access_in = 1'b0;
    wait_in      = 1'b0;
    last_win     = '0;
    #1 sys_nreset = 1'b1;
    step(3'b000, 3'b000, 3'b000, 1'b0);
    // Pointer back at rr after reset.
    step(3'b111, 3'b001, 3'b001, 1'b0);
    step(3'b000, 3'b000, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_replay_access", 128'(access_out), 128'(0));
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
